// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared constants, table markers and state encoding for the OV7670 SCCB configurator
package cam_pkg;

    localparam logic [7:0]  CAM_SCCB_ADDR = 8'h42;
    localparam logic [15:0] TBL_END       = 16'hFFFF;
    localparam logic [15:0] TBL_DELAY     = 16'hFFF0;

    localparam logic [4:0]  LAST_SLOT     = 5'd26;

    typedef logic [3:0] cam_state_t;

    localparam cam_state_t ST_IDLE  = 4'd0;
    localparam cam_state_t ST_PWRUP = 4'd1;
    localparam cam_state_t ST_FETCH = 4'd2;
    localparam cam_state_t ST_START = 4'd3;
    localparam cam_state_t ST_BITS  = 4'd4;
    localparam cam_state_t ST_STOP  = 4'd5;
    localparam cam_state_t ST_GAP   = 4'd6;
    localparam cam_state_t ST_DELAY = 4'd7;
    localparam cam_state_t ST_DONE  = 4'd8;

    // The ninth slot of each 3-phase byte is the sensor's don't-care/ACK bit.
    function automatic logic is_dc_slot(input logic [4:0] slot);
        return (slot == 5'd8) || (slot == 5'd17) || (slot == 5'd26);
    endfunction

endpackage

// File: rtl/cam_sccb_config_if.sv
// rtl/cam_sccb_config_if.sv - control and SCCB line bundle between configurator and top level
interface cam_sccb_config_if #(
    parameter int ROM_AW = 6
) ();

    logic              start;
    logic              sioc;
    logic              siod_o;
    logic              siod_oe;
    logic              busy;
    logic              done;
    logic [ROM_AW-1:0] reg_idx;

    modport master (
        input  start,
        output sioc,
        output siod_o,
        output siod_oe,
        output busy,
        output done,
        output reg_idx
    );

    modport slave (
        output start,
        input  sioc,
        input  siod_o,
        input  siod_oe,
        input  busy,
        input  done,
        input  reg_idx
    );

endinterface

// File: rtl/cam_reg_rom.sv
// rtl/cam_reg_rom.sv - OV7670 {reg, val} table for QQVGA RGB565, one-cycle registered read
module cam_reg_rom
    import cam_pkg::*;
#(
    parameter int ROM_AW = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROM_AW-1:0] addr,
    output logic [15:0]       data
);

    logic [15:0] data_q, data_d;

    always_comb begin
        data_d = TBL_END;
        case (int'(addr))
            0: data_d = 16'h1280;       // soft reset
            1: data_d = TBL_DELAY;      // let the sensor settle after reset
            2: data_d = 16'h1214;
            3: data_d = 16'h40D0;
            4: data_d = 16'h8C00;
            5: data_d = 16'h0C04;
            6: data_d = 16'h3E1A;
            7: data_d = 16'h7222;
            8: data_d = 16'h73F2;
            default: data_d = TBL_END;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= TBL_END;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/cam_sccb_config.sv
// rtl/cam_sccb_config.sv - walks the register table and writes each entry to the OV7670 over SCCB
module cam_sccb_config
    import cam_pkg::*;
#(
    parameter int         CLK_FREQ  = 50_000_000,
    parameter int         SCCB_FREQ = 100_000,
    parameter logic [7:0] DEV_ADDR  = CAM_SCCB_ADDR,
    parameter int         PWRUP_CYC = 50_000,
    parameter int         DELAY_CYC = 500_000,
    parameter int         ROM_AW    = 6
) (
    input logic         clk,
    input logic         rst,
    cam_sccb_config_if.master bus
);

    localparam int QTR = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int TW  = (QTR > 1) ? $clog2(QTR) : 1;

    cam_state_t        state_q, state_d;
    logic [1:0]        qtr_q, qtr_d;
    logic [4:0]        slot_q, slot_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [31:0]       wait_q, wait_d;
    logic              fetch_q, fetch_d;
    logic [23:0]       shift_q, shift_d;
    logic [ROM_AW-1:0] reg_idx_q, reg_idx_d;
    logic              sioc_q, sioc_d;
    logic              siod_q, siod_d;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [15:0]       rom_data;
    logic              tick;

    cam_reg_rom #(.ROM_AW(ROM_AW)) u_rom (
        .clk  (clk),
        .rst  (rst),
        .addr (reg_idx_q),
        .data (rom_data)
    );

    assign tick = (tick_q == TW'(QTR - 1));

    always_comb begin
        state_d   = state_q;
        qtr_d     = qtr_q;
        slot_d    = slot_q;
        tick_d    = tick_q;
        wait_d    = wait_q;
        fetch_d   = fetch_q;
        shift_d   = shift_q;
        reg_idx_d = reg_idx_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d   = ST_PWRUP;
                    reg_idx_d = '0;
                    wait_d    = '0;
                end
            end
            ST_PWRUP: begin
                if (wait_q == 32'(PWRUP_CYC - 1)) begin
                    state_d = ST_FETCH;
                    wait_d  = '0;
                    fetch_d = 1'b0;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            ST_FETCH: begin
                // First cycle presents the address, second sees registered ROM data.
                if (!fetch_q) begin
                    fetch_d = 1'b1;
                end else begin
                    fetch_d = 1'b0;
                    if (rom_data == TBL_END || reg_idx_q == {ROM_AW{1'b1}}) begin
                        state_d = ST_DONE;
                    end else if (rom_data == TBL_DELAY) begin
                        state_d = ST_DELAY;
                        wait_d  = '0;
                    end else begin
                        state_d = ST_START;
                        shift_d = {DEV_ADDR, rom_data};
                        qtr_d   = 2'd0;
                        slot_d  = 5'd0;
                        tick_d  = '0;
                    end
                end
            end
            ST_DELAY: begin
                if (wait_q == 32'(DELAY_CYC - 1)) begin
                    state_d   = ST_FETCH;
                    wait_d    = '0;
                    fetch_d   = 1'b0;
                    reg_idx_d = reg_idx_q + 1'b1;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            ST_START, ST_BITS, ST_STOP, ST_GAP: begin
                tick_d = tick ? '0 : tick_q + 1'b1;
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    case (state_q)
                        ST_START: begin
                            if (qtr_q == 2'd3) begin
                                state_d = ST_BITS;
                                slot_d  = 5'd0;
                            end
                        end
                        ST_BITS: begin
                            if (qtr_q == 2'd3) begin
                                if (slot_q == LAST_SLOT) begin
                                    state_d = ST_STOP;
                                end else begin
                                    slot_d = slot_q + 5'd1;
                                end
                                if (!is_dc_slot(slot_q)) begin
                                    shift_d = {shift_q[22:0], 1'b0};
                                end
                            end
                        end
                        ST_STOP: begin
                            if (qtr_q == 2'd2) begin
                                state_d = ST_GAP;
                                qtr_d   = 2'd0;
                            end
                        end
                        default: begin
                            if (qtr_q == 2'd3) begin
                                state_d   = ST_FETCH;
                                fetch_d   = 1'b0;
                                reg_idx_d = reg_idx_q + 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line levels are decoded from the next state so the pins change on the same edge as the FSM.
    always_comb begin
        sioc_d = 1'b1;
        siod_d = 1'b1;
        oe_d   = 1'b1;
        case (state_d)
            ST_START: begin
                // SIOC stays low for the last three quarters so the start phase spans a full slot.
                siod_d = 1'b0;
                sioc_d = (qtr_d == 2'd0);
            end
            ST_BITS: begin
                sioc_d = qtr_d[1];
                if (is_dc_slot(slot_d)) begin
                    oe_d = 1'b0;
                end else begin
                    siod_d = shift_d[23];
                end
            end
            ST_STOP: begin
                sioc_d = (qtr_d != 2'd0);
                siod_d = (qtr_d == 2'd2);
            end
            default: ;
        endcase
        busy_d = !(state_d == ST_IDLE || state_d == ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            qtr_q     <= 2'd0;
            slot_q    <= 5'd0;
            tick_q    <= '0;
            wait_q    <= '0;
            fetch_q   <= 1'b0;
            shift_q   <= '0;
            reg_idx_q <= '0;
            sioc_q    <= 1'b1;
            siod_q    <= 1'b1;
            oe_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            qtr_q     <= qtr_d;
            slot_q    <= slot_d;
            tick_q    <= tick_d;
            wait_q    <= wait_d;
            fetch_q   <= fetch_d;
            shift_q   <= shift_d;
            reg_idx_q <= reg_idx_d;
            sioc_q    <= sioc_d;
            siod_q    <= siod_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.sioc    = sioc_q;
    assign bus.siod_o  = siod_q;
    assign bus.siod_oe = oe_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.reg_idx = reg_idx_q;

endmodule
